axi_lite_sram_slv: RTL and testbench

AXI-Lite responder backed by an on-chip word-addressed SRAM array; it is the memory-side endpoint for the LSU and IFU AXI-Lite masters in the NPC simulation top. Read and write channels are served by independent state machines with configurable response latency, so the pipeline's back-pressure handling can be exercised. Narrow accesses follow the core's right-justified lane convention: byte/half data and strobes are carried in the low lanes of the bus.

---
 rtl/axi_lite_sram_slv.sv | 190 +++++++++++++++++++
 tb/tb_axi_lite_sram_slv.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_sram_slv.sv
// AXI-Lite responder over a word-addressed SRAM; read and write channels run independent FSMs.
// Optional latency jitter: define YSYX_23060251_SRAM_RAND_DELAY_EN.
package axi_lite_sram_slv_pkg;
  typedef logic [1:0] axi_resp_t;
  localparam axi_resp_t RESP_OKAY   = 2'b00;
  localparam axi_resp_t RESP_DECERR = 2'b11;
endpackage

module axi_lite_sram_slv
  import axi_lite_sram_slv_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       DEPTH     = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned       LATENCY   = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                slv_ar_valid_i,
  output logic                slv_ar_ready_o,
  input  logic [ADDR_W-1:0]   slv_ar_addr_i,
  output logic                slv_r_valid_o,
  input  logic                slv_r_ready_i,
  output logic [DATA_W-1:0]   slv_r_data_o,
  output axi_resp_t           slv_r_resp_o,
  input  logic                slv_aw_valid_i,
  output logic                slv_aw_ready_o,
  input  logic [ADDR_W-1:0]   slv_aw_addr_i,
  input  logic                slv_w_valid_i,
  output logic                slv_w_ready_o,
  input  logic [DATA_W-1:0]   slv_w_data_i,
  input  logic [DATA_W/8-1:0] slv_w_strb_i,
  output logic                slv_b_valid_o,
  input  logic                slv_b_ready_i,
  output axi_resp_t           slv_b_resp_o
);
  localparam int unsigned     STRB_W = DATA_W / 8;
  localparam int unsigned     IDX_W  = $clog2(DEPTH);
  localparam int unsigned     CNT_W  = 5;
  localparam logic [ADDR_W:0] SPAN   = (ADDR_W+1)'(4 * DEPTH);

  typedef enum logic [2:0] {R_IDLE = 3'b001, R_DELAY = 3'b010, R_RESP = 3'b100} r_state_e;
  typedef enum logic [3:0] {W_IDLE = 4'b0001, W_DATA = 4'b0010, W_DELAY = 4'b0100, W_RESP = 4'b1000} w_state_e;

  logic [DATA_W-1:0] mem_q [DEPTH];

  r_state_e          r_state_q, r_state_d;
  w_state_e          w_state_q, w_state_d;
  logic [CNT_W-1:0]  r_cnt_q, r_cnt_d, w_cnt_q, w_cnt_d, w_lat_q, w_lat_d;
  logic [ADDR_W-1:0] ar_addr_q, ar_addr_d, aw_addr_q, aw_addr_d;
  logic [DATA_W-1:0] r_data_q;
  axi_resp_t         r_resp_q, b_resp_q, b_resp_d;
  logic              init_q;
  logic [CNT_W-1:0]  eff_lat;

`ifdef YSYX_23060251_SRAM_RAND_DELAY_EN
  logic [15:0] lfsr_q;
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) lfsr_q <= 16'hACE1;
    else        lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end
  assign eff_lat = CNT_W'(LATENCY) + CNT_W'(lfsr_q[2:0]);
`else
  assign eff_lat = CNT_W'(LATENCY);
`endif

  // Readys are held low until the first edge after reset release.
  assign slv_ar_ready_o = init_q && (r_state_q == R_IDLE);
  assign slv_aw_ready_o = init_q && (w_state_q == W_IDLE);
  assign slv_w_ready_o  = (w_state_q == W_DATA);
  assign slv_r_valid_o  = (r_state_q == R_RESP);
  assign slv_b_valid_o  = (w_state_q == W_RESP);
  assign slv_r_data_o   = r_data_q;
  assign slv_r_resp_o   = r_resp_q;
  assign slv_b_resp_o   = b_resp_q;

  logic ar_hs, aw_hs, w_hs;
  assign ar_hs = slv_ar_valid_i && slv_ar_ready_o;
  assign aw_hs = slv_aw_valid_i && slv_aw_ready_o;
  assign w_hs  = slv_w_valid_i && slv_w_ready_o;

  // With zero latency the capture happens on the ar handshake edge, so decode the live address.
  logic [ADDR_W-1:0] rd_addr, rd_rel, wr_rel;
  logic              rd_hit, wr_hit, r_load, wr_en;
  logic [IDX_W-1:0]  rd_idx, wr_idx;
  logic [STRB_W-1:0] strb_sh;
  logic [DATA_W-1:0] data_sh;

  assign rd_addr = (r_state_q == R_IDLE) ? slv_ar_addr_i : ar_addr_q;
  assign rd_rel  = rd_addr - BASE_ADDR;
  assign rd_hit  = (rd_addr >= BASE_ADDR) && ({1'b0, rd_rel} < SPAN);
  assign rd_idx  = rd_rel[IDX_W+1:2];
  assign r_load  = (r_state_d == R_RESP) && (r_state_q != R_RESP);

  assign wr_rel  = aw_addr_q - BASE_ADDR;
  assign wr_hit  = (aw_addr_q >= BASE_ADDR) && ({1'b0, wr_rel} < SPAN);
  assign wr_idx  = wr_rel[IDX_W+1:2];
  assign wr_en   = w_hs && wr_hit;
  assign strb_sh = slv_w_strb_i << aw_addr_q[1:0];
  assign data_sh = slv_w_data_i << {aw_addr_q[1:0], 3'b000};

  always_comb begin
    r_state_d = r_state_q;
    r_cnt_d   = r_cnt_q;
    ar_addr_d = ar_addr_q;
    case (r_state_q)
      R_IDLE: if (ar_hs) begin
        ar_addr_d = slv_ar_addr_i;
        if (eff_lat == '0) begin
          r_state_d = R_RESP;
        end else begin
          r_state_d = R_DELAY;
          r_cnt_d   = eff_lat - CNT_W'(1);
        end
      end
      R_DELAY: if (r_cnt_q == '0) r_state_d = R_RESP;
               else               r_cnt_d   = r_cnt_q - CNT_W'(1);
      R_RESP:  if (slv_r_ready_i) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    w_state_d = w_state_q;
    w_cnt_d   = w_cnt_q;
    w_lat_d   = w_lat_q;
    aw_addr_d = aw_addr_q;
    b_resp_d  = b_resp_q;
    case (w_state_q)
      W_IDLE: if (aw_hs) begin
        aw_addr_d = slv_aw_addr_i;
        w_lat_d   = eff_lat;
        w_state_d = W_DATA;
      end
      W_DATA: if (w_hs) begin
        b_resp_d = wr_hit ? RESP_OKAY : RESP_DECERR;
        if (w_lat_q == '0) begin
          w_state_d = W_RESP;
        end else begin
          w_state_d = W_DELAY;
          w_cnt_d   = w_lat_q - CNT_W'(1);
        end
      end
      W_DELAY: if (w_cnt_q == '0) w_state_d = W_RESP;
               else               w_cnt_d   = w_cnt_q - CNT_W'(1);
      W_RESP:  if (slv_b_ready_i) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      init_q    <= 1'b0;
      r_state_q <= R_IDLE;
      r_cnt_q   <= '0;
      ar_addr_q <= '0;
      r_data_q  <= '0;
      r_resp_q  <= RESP_OKAY;
      w_state_q <= W_IDLE;
      w_cnt_q   <= '0;
      w_lat_q   <= '0;
      aw_addr_q <= '0;
      b_resp_q  <= RESP_OKAY;
    end else begin
      init_q    <= 1'b1;
      r_state_q <= r_state_d;
      r_cnt_q   <= r_cnt_d;
      ar_addr_q <= ar_addr_d;
      w_state_q <= w_state_d;
      w_cnt_q   <= w_cnt_d;
      w_lat_q   <= w_lat_d;
      aw_addr_q <= aw_addr_d;
      b_resp_q  <= b_resp_d;
      if (r_load) begin
        r_data_q <= rd_hit ? (mem_q[rd_idx] >> {rd_addr[1:0], 3'b000}) : '0;
        r_resp_q <= rd_hit ? RESP_OKAY : RESP_DECERR;
      end
    end
  end

  // Array is never reset: a write committed before reset survives it.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (strb_sh[i]) mem_q[wr_idx][8*i +: 8] <= data_sh[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_axi_lite_sram_slv.sv
// Directed + random bench for axi_lite_sram_slv with a per-channel response scoreboard.
module tb_axi_lite_sram_slv;
  localparam int          LAT   = 1;
  localparam int          DEPTH = 4096;
  localparam logic [31:0] BASE  = 32'h8000_0000;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        ar_valid = 1'b0, ar_ready, r_valid, r_ready = 1'b1;
  logic [31:0] ar_addr = '0, r_data;
  logic [1:0]  r_resp, b_resp;
  logic        aw_valid = 1'b0, aw_ready, w_valid = 1'b0, w_ready, b_valid, b_ready = 1'b1;
  logic [31:0] aw_addr = '0, w_data = '0;
  logic [3:0]  w_strb = '0;

  always #5 clk = ~clk;

  axi_lite_sram_slv #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT)
  ) dut (
    .clk_i(clk), .rst_i(rst_n),
    .slv_ar_valid_i(ar_valid), .slv_ar_ready_o(ar_ready), .slv_ar_addr_i(ar_addr),
    .slv_r_valid_o(r_valid), .slv_r_ready_i(r_ready), .slv_r_data_o(r_data), .slv_r_resp_o(r_resp),
    .slv_aw_valid_i(aw_valid), .slv_aw_ready_o(aw_ready), .slv_aw_addr_i(aw_addr),
    .slv_w_valid_i(w_valid), .slv_w_ready_o(w_ready), .slv_w_data_i(w_data), .slv_w_strb_i(w_strb),
    .slv_b_valid_o(b_valid), .slv_b_ready_i(b_ready), .slv_b_resp_o(b_resp)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {logic [31:0] data; logic [1:0] resp;} rd_exp_t;
  rd_exp_t    rd_sb[$];
  logic [1:0] wr_sb[$];
  logic [31:0] model [8];
  logic [31:0] word10;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_lat(input string tag, input int lat);
`ifdef YSYX_23060251_SRAM_RAND_DELAY_EN
    check(tag, 32'(lat >= 1 + LAT && lat <= 8 + LAT), 1);
`else
    check(tag, lat, 1 + LAT);
`endif
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data,
                         input logic [1:0] exp_resp, input int hold);
    rd_exp_t e;
    int      n;
    int      lat;
    rd_sb.push_back('{data: exp_data, resp: exp_resp});
    r_ready  = (hold == 0);
    ar_addr  = addr;
    ar_valid = 1'b1;
    n = 0;
    while (!ar_ready && n < 100) begin tick(); n++; end
    check("ar_ready", 32'(ar_ready), 1);
    tick();
    ar_valid = 1'b0;
    lat = 1;
    while (!r_valid && lat < 100) begin tick(); lat++; end
    check("r_valid", 32'(r_valid), 1);
    check_lat("rd_latency", lat);
    e = rd_sb.pop_front();
    repeat (hold) begin
      check("r_hold_valid", 32'(r_valid), 1);
      check("r_hold_ar_ready", 32'(ar_ready), 0);
      check("r_hold_data", r_data, e.data);
      tick();
    end
    check("r_data", r_data, e.data);
    check("r_resp", 32'(r_resp), 32'(e.resp));
    r_ready = 1'b1;
    tick();
    check("r_valid_drop", 32'(r_valid), 0);
    check("ar_ready_back", 32'(ar_ready), 1);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input logic [1:0] exp_resp, input int hold);
    logic [1:0] e;
    int         n;
    int         lat;
    wr_sb.push_back(exp_resp);
    b_ready  = (hold == 0);
    aw_addr  = addr;
    aw_valid = 1'b1;
    n = 0;
    while (!aw_ready && n < 100) begin tick(); n++; end
    check("aw_ready", 32'(aw_ready), 1);
    tick();
    aw_valid = 1'b0;
    check("w_ready", 32'(w_ready), 1);
    check("aw_ready_busy", 32'(aw_ready), 0);
    w_data  = data;
    w_strb  = strb;
    w_valid = 1'b1;
    tick();
    w_valid = 1'b0;
    lat = 1;
    while (!b_valid && lat < 100) begin tick(); lat++; end
    check("b_valid", 32'(b_valid), 1);
    check_lat("wr_latency", lat);
    e = wr_sb.pop_front();
    repeat (hold) begin
      check("b_hold_valid", 32'(b_valid), 1);
      check("b_hold_aw_ready", 32'(aw_ready), 0);
      check("b_hold_resp", 32'(b_resp), 32'(e));
      tick();
    end
    check("b_resp", 32'(b_resp), 32'(e));
    b_ready = 1'b1;
    tick();
    check("b_valid_drop", 32'(b_valid), 0);
    check("aw_ready_back", 32'(aw_ready), 1);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int off;
    int nrand;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ar_ready", 32'(ar_ready), 0);
    check("rst_aw_ready", 32'(aw_ready), 0);
    check("rst_w_ready", 32'(w_ready), 0);
    check("rst_r_valid", 32'(r_valid), 0);
    check("rst_b_valid", 32'(b_valid), 0);
    check("rst_r_data", r_data, 0);
    check("rst_r_resp", 32'(r_resp), 0);
    check("rst_b_resp", 32'(b_resp), 0);
    rst_n = 1'b1;
    tick();
    check("post_rst_ar_ready", 32'(ar_ready), 1);
    check("post_rst_aw_ready", 32'(aw_ready), 1);
    check("post_rst_w_ready", 32'(w_ready), 0);

    // Word and byte-lane accesses
    do_write(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 2'b00, 0);
    do_read (BASE + 32'h10, 32'hDEAD_BEEF, 2'b00, 0);
    do_write(BASE + 32'h12, 32'h0000_005A, 4'h1, 2'b00, 0);
    do_read (BASE + 32'h10, 32'hDE5A_BEEF, 2'b00, 0);
    do_read (BASE + 32'h13, 32'h0000_00DE, 2'b00, 0);
    do_read (BASE + 32'h12, 32'h0000_DE5A, 2'b00, 0);
    word10 = 32'hDE5A_BEEF;

    // Range boundaries
    do_write(BASE, 32'h1234_5678, 4'hF, 2'b00, 0);
    do_read (32'h7FFF_FFFC, 32'h0, 2'b11, 0);
    do_write(BASE + 4 * DEPTH, 32'hFFFF_FFFF, 4'hF, 2'b11, 0);
    do_read (BASE + 4 * DEPTH, 32'h0, 2'b11, 0);
    do_read (BASE, 32'h1234_5678, 2'b00, 0);
    do_write(BASE + 4 * DEPTH - 4, 32'hCAFE_F00D, 4'hF, 2'b00, 0);
    do_read (BASE + 4 * DEPTH - 4, 32'hCAFE_F00D, 2'b00, 0);

    // Back-pressure on both response channels
    do_read (BASE + 32'h10, word10, 2'b00, 10);
    do_write(BASE + 32'h20, 32'h0BAD_CAFE, 4'hF, 2'b00, 10);
    do_read (BASE + 32'h20, 32'h0BAD_CAFE, 2'b00, 0);

    // Concurrent read and write to different words
    fork
      do_read (BASE + 32'h10, word10, 2'b00, 0);
      do_write(BASE + 32'h30, 32'h1111_2222, 4'hF, 2'b00, 0);
    join
    do_read(BASE + 32'h30, 32'h1111_2222, 2'b00, 0);

`ifndef YSYX_23060251_SRAM_RAND_DELAY_EN
    // Same-edge read capture and write commit to one word sees the old data
    fork
      do_read (BASE + 32'h10, word10, 2'b00, 0);
      do_write(BASE + 32'h10, 32'h7777_7777, 4'hF, 2'b00, 0);
    join
    word10 = 32'h7777_7777;
    do_read(BASE + 32'h10, word10, 2'b00, 0);
`endif

    // Reset while a read is waiting out its latency
    ar_addr  = BASE + 32'h10;
    ar_valid = 1'b1;
    tick();
    ar_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    repeat (3) begin
      check("mid_rst_r_valid", 32'(r_valid), 0);
      check("mid_rst_ar_ready", 32'(ar_ready), 0);
      check("mid_rst_aw_ready", 32'(aw_ready), 0);
      tick();
    end
    rst_n = 1'b1;
    tick();
    check("rerst_ar_ready", 32'(ar_ready), 1);
    repeat (4) begin
      check("rerst_r_valid", 32'(r_valid), 0);
      tick();
    end
    do_read(BASE + 32'h10, word10, 2'b00, 0);

    // Random offsets over a written region
    for (int i = 0; i < 8; i++) begin
      model[i] = $urandom;
      do_write(BASE + 32'h100 + 32'(4 * i), model[i], 4'hF, 2'b00, 0);
    end
`ifdef YSYX_23060251_SRAM_RAND_DELAY_EN
    nrand = 200;
`else
    nrand = 24;
`endif
    for (int i = 0; i < nrand; i++) begin
      idx = $urandom_range(0, 7);
      off = $urandom_range(0, 3);
      do_read(BASE + 32'h100 + 32'(4 * idx + off), model[idx] >> (8 * off), 2'b00, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
